mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
Multiply/divide unit in the E stage of the pipelined MIPS core. It consumes the 4-bit MDUop code and the forwarded rs/rt operands produced by the decode logic, and owns the architectural HI/LO registers. It models multi-cycle latency through a busy counter so the hazard unit can stall md/mf/mt instructions. It returns HI or LO for mfhi/mflo to the E-stage result mux.

Parameters:
MULT_CYCLES, 5, busy duration in cycles for mult/multu
DIV_CYCLES, 10, busy duration in cycles for div/divu

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
MDUop  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none
A  input  32  forwarded rs value (E stage)
B  input  32  forwarded rt value (E stage)
start  output  1  combinational, 1 when MDUop is in 1..4 and busy=0
busy  output  1  registered, 1 while a mult/div is in flight
HI  output  32  architectural HI register
LO  output  32  architectural LO register
MDU_out  output  32  combinational; HI when MDUop=5, LO when MDUop=6, else 0

Behaviour:
- Reset (asynchronous, any time, including mid-operation): busy=0, counter=0, HI=0, LO=0, shadow_hi=0, shadow_lo=0. An in-flight result is discarded.
- State machine has 2 states. IDLE (busy=0) and RUN (busy=1). counter is 4 bits and is wide enough for DIV_CYCLES.
- IDLE with start=1 at the edge closing cycle T:
  - Compute the result into shadow_hi/shadow_lo.
  - Set counter to MULT_CYCLES or DIV_CYCLES.
  - Set busy to 1. busy is then high in cycles T+1..T+N.
- RUN: counter decrements each edge. At the edge where counter==1: HI<=shadow_hi, LO<=shadow_lo, busy<=0, return to IDLE. The new HI/LO are first visible in cycle T+N+1.
- Arithmetic:
  - mult: signed 32x32, 64-bit product; HI=product[63:32], LO=product[31:0].
  - multu: same split, unsigned product.
  - div: LO=signed quotient truncated toward zero; HI=remainder with the sign of the dividend A.
  - divu: unsigned quotient and remainder.
- Divide by zero (B=0, div or divu): busy runs the full DIV_CYCLES, then HI and LO keep their prior values (shadow loaded from the current HI/LO).
- mthi/mtlo with busy=0: HI or LO <= A at the closing edge; no busy.
- mfhi/mflo: purely combinational read of the current HI/LO. Neither changes state.
- Any MDUop 1..8 arriving while busy=1 is ignored: no state change, start=0. The hazard unit stalls these in D whenever start|busy. The block does not rely on that guarantee for correctness.
- mthi/mtlo/mf while busy=0 do not affect busy.
- MDUop=0 or 9..15: no effect.
- HI/LO change only on a RUN completion edge, an mt edge, or reset.

Test Plan:
- Reset, then MDUop=0 for 3 cycles -> HI=LO=0, busy=0, start=0, MDU_out=0.
- mult, A=0xFFFFFFFF, B=2 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu, same operands -> 5 busy cycles; then HI=0x00000001, LO=0xFFFFFFFE.
- Signed division:
  - div, A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu, A=7, B=2 -> LO=3, HI=1.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0, then mfhi/mflo -> MDU_out=0x12345678, then 0x9ABCDEF0.
- Busy and reset edge cases:
  - div with B=0 after mt preload -> busy 10 cycles; HI/LO unchanged.
  - mult issued with busy=1 (e.g. mult A=3, B=3 in cycle T+2 of a 5-cycle mult) -> ignored, start=0.
  - Reset asserted in cycle T+3 of a mult -> busy=0 and HI=LO=0 immediately; no late HI/LO update.

Source files
------------

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit owning HI/LO.
// Results land in a shadow pair and retire when the busy countdown expires.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_out
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] sh_hi, sh_lo;
  logic [31:0] sh_hi_n, sh_lo_n;
  logic [31:0] hi_n, lo_n;
  logic [63:0] prod_s, prod_u;
  logic [31:0] sq, sr, uq, ur;
  logic        is_md, b_zero;

  assign prod_s = $signed({{32{A[31]}}, A})
                * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign b_zero = (B == 32'd0);

  // 33-bit operands keep -2^31 / -1 well defined
  assign sq = b_zero ? 32'd0 :
    32'($signed({A[31], A}) / $signed({B[31], B}));
  assign sr = b_zero ? 32'd0 :
    32'($signed({A[31], A}) % $signed({B[31], B}));
  assign uq = b_zero ? 32'd0 : A / B;
  assign ur = b_zero ? 32'd0 : A % B;

  assign is_md = (MDUop >= 4'd1) && (MDUop <= 4'd4);
  assign start = is_md && (state == IDLE);
  assign busy  = (state == RUN);

  always_comb begin
    MDU_out = 32'd0;
    if (MDUop == 4'd5) MDU_out = HI;
    else if (MDUop == 4'd6) MDU_out = LO;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_hi_n = sh_hi;
    sh_lo_n = sh_lo;
    hi_n    = HI;
    lo_n    = LO;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          cnt_n = (MDUop <= 4'd2) ? 4'(MULT_CYCLES)
                                  : 4'(DIV_CYCLES);
          case (MDUop)
            4'd1: {sh_hi_n, sh_lo_n} = prod_s;
            4'd2: {sh_hi_n, sh_lo_n} = prod_u;
            default: begin
              // divide by zero retires the current HI/LO
              sh_hi_n = b_zero ? HI : (MDUop == 4'd3 ? sr : ur);
              sh_lo_n = b_zero ? LO : (MDUop == 4'd3 ? sq : uq);
            end
          endcase
        end else if (MDUop == 4'd7) begin
          hi_n = A;
        end else if (MDUop == 4'd8) begin
          lo_n = A;
        end
      end
      RUN: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_n = IDLE;
          hi_n    = sh_hi;
          lo_n    = sh_lo;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      sh_hi <= 32'd0;
      sh_lo <= 32'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sh_hi <= sh_hi_n;
      sh_lo <= sh_lo_n;
      HI    <= hi_n;
      LO    <= lo_n;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: directed cases then random ops
// against an arithmetic reference model of HI/LO.
module tb_mdu_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDUop;
  logic [31:0] A, B;
  logic        start, busy;
  logic [31:0] HI, LO, MDU_out;

  int errors = 0;
  int checks = 0;

  logic [63:0] res_q[$];
  logic [31:0] mf_q[$];
  logic [31:0] mhi = 32'd0;
  logic [31:0] mlo = 32'd0;
  logic        prev_busy = 1'b0;

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .MDUop(MDUop),
    .A(A), .B(B), .start(start), .busy(busy),
    .HI(HI), .LO(LO), .MDU_out(MDU_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // completions and mf reads are checked here, decoupled from stimulus
  always @(negedge clk) begin
    if (reset) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !busy) begin
        if (res_q.size() == 0) check("spurious_done", 1, 0);
        else check("hi_lo_done", {HI, LO}, res_q.pop_front());
      end
      if (MDUop == 4'd5 || MDUop == 4'd6) begin
        if (mf_q.size() == 0) check("spurious_mf", 1, 0);
        else check("mdu_out", {32'd0, MDU_out},
                   {32'd0, mf_q.pop_front()});
      end
      prev_busy = busy;
    end
  end

  function automatic void ref_op(input logic [3:0] op,
                                 input logic [31:0] a, b,
                                 output logic [31:0] h, l);
    longint sp, sa, sb, q, r;
    longint unsigned up;
    h = mhi;
    l = mlo;
    case (op)
      4'd1: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        h = sp[63:32]; l = sp[31:0];
      end
      4'd2: begin
        up = longint'(a) * longint'(b);
        h = up[63:32]; l = up[31:0];
      end
      4'd3: if (b != 0) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = sa / sb; r = sa % sb;
        h = r[31:0]; l = q[31:0];
      end
      4'd4: if (b != 0) begin
        h = a % b; l = a / b;
      end
      4'd7: h = a;
      4'd8: l = a;
      default: ;
    endcase
  endfunction

  task automatic wait_done(input int exp_n);
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    check("busy_cycles", 64'(n), 64'(exp_n));
  endtask

  task automatic run(input logic [3:0] op,
                     input logic [31:0] a, b, eh, el,
                     input bit nowait);
    bit md = (op >= 4'd1 && op <= 4'd4);
    if (op == 4'd5) mf_q.push_back(mhi);
    if (op == 4'd6) mf_q.push_back(mlo);
    if (md) res_q.push_back({eh, el});
    @(posedge clk); #1;
    MDUop = op; A = a; B = b;
    @(negedge clk);
    check("start", {63'd0, start}, {63'd0, md});
    @(posedge clk); #1;
    MDUop = 4'd0;
    mhi = eh;
    mlo = el;
    if (md) begin
      if (!nowait) wait_done(op <= 4'd2 ? MC : DC);
    end else begin
      check("hi_lo_hold", {HI, LO}, {eh, el});
    end
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b, rh, rl;
    reset = 1'b1; MDUop = 4'd0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hi_lo", {HI, LO}, 64'd0);
    check("reset_flags", {62'd0, busy, start}, 64'd0);
    check("reset_out", {32'd0, MDU_out}, 64'd0);

    run(1, 32'hFFFFFFFF, 2, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
    run(2, 32'hFFFFFFFF, 2, 32'h00000001, 32'hFFFFFFFE, 0);
    run(3, 32'hFFFFFFF9, 2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run(4, 7, 2, 32'd1, 32'd3, 0);
    run(7, 32'h12345678, 0, 32'h12345678, 32'd3, 0);
    run(8, 32'h9ABCDEF0, 0, 32'h12345678, 32'h9ABCDEF0, 0);
    run(5, 0, 0, 32'h12345678, 32'h9ABCDEF0, 0);
    run(6, 0, 0, 32'h12345678, 32'h9ABCDEF0, 0);
    run(3, 32'd100, 0, 32'h12345678, 32'h9ABCDEF0, 0);
    run(4, 32'd100, 0, 32'h12345678, 32'h9ABCDEF0, 0);

    // mult arriving mid-flight must be dropped
    run(1, 32'd6, 32'd7, 32'd0, 32'd42, 1);
    @(posedge clk); #1;
    MDUop = 4'd1; A = 32'd3; B = 32'd3;
    @(negedge clk);
    check("start_busy", {62'd0, start, busy}, 64'd1);
    @(posedge clk); #1;
    MDUop = 4'd0;
    wait_done(3);

    // reset in the middle of a mult drops the result
    run(7, 32'h11111111, 0, 32'h11111111, 32'd42, 0);
    run(1, 32'd5, 32'd7, 32'd0, 32'd35, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midrst_now", {HI, LO}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    res_q.delete();
    mhi = 32'd0; mlo = 32'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("midrst_late", {HI, LO}, 64'd0);

    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b % 32'd9;
      if ($urandom_range(0, 3) == 0) a = a % 32'd100;
      ref_op(op, a, b, rh, rl);
      run(op, a, b, rh, rl, 0);
    end

    repeat (2) @(negedge clk);
    check("queues_empty", 64'(res_q.size() + mf_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
